// File: rtl/pt2262_pkg.sv
// pt2262_pkg: shared types and counter widths for the PT2262 transmit scheduler.
`default_nettype none

package pt2262_pkg;

  localparam int FRAME_CNT_W = 4;
  localparam int TO_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] float_mask;
    logic [3:0] data;
  } pt_word_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from last_grant+1 upward.
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int GW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic             valid,
  output logic [GW-1:0]    winner
);

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      logic [GW-1:0] sel;
      sel = GW'((int'(last_grant) + k) % N_REQ);
      if (req[sel]) begin
        valid  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pt2262_tx_scheduler.sv
// pt2262_tx_scheduler: shares one PT2262 encoder among N_REQ requesters,
// swapping words only on sync rises and holding each for FRAMES frames.
`default_nettype none

module pt2262_tx_scheduler
  import pt2262_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FRAMES       = 4,
  parameter int SYNC_TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*8-1:0]       req_addr,
  input  logic [N_REQ*8-1:0]       req_float,
  input  logic [N_REQ*4-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  output logic                     abort,
  input  logic                     enc_sync,
  output logic [7:0]               enc_addr,
  output logic [7:0]               enc_float,
  output logic [3:0]               enc_data,
  output logic                     tx_active,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(N_REQ);
  localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(FRAMES - 1);
  localparam logic [TO_CNT_W-1:0]    TO_LAST    = TO_CNT_W'(SYNC_TIMEOUT - 1);

  sched_state_t           state;
  logic                   sync_q;
  logic                   rise;
  pt_word_t               hold;
  logic [GW-1:0]          hold_id;
  logic [GW-1:0]          last_grant;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [TO_CNT_W-1:0]    to_cnt;
  logic [TO_CNT_W-1:0]    to_cnt_inc;
  logic                   timeout_hit;

  logic [N_REQ-1:0]       arb_req;
  logic [GW-1:0]          arb_last;
  logic                   arb_valid;
  logic [GW-1:0]          arb_winner;
  pt_word_t               win_word;

  assign rise        = enc_sync & ~sync_q;
  assign timeout_hit = (to_cnt == TO_LAST);
  assign to_cnt_inc  = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;

  // In SEND the arbiter serves the back-to-back pick: the current owner is
  // excluded and treated as the new last_grant.
  always_comb begin
    arb_req  = req;
    arb_last = last_grant;
    if (state == SEND) begin
      arb_req  = req & ~(N_REQ'(1) << grant_id);
      arb_last = grant_id;
    end
  end

  rr_arbiter #(
    .N_REQ(N_REQ),
    .GW   (GW)
  ) u_arb (
    .req       (arb_req),
    .last_grant(arb_last),
    .valid     (arb_valid),
    .winner    (arb_winner)
  );

  always_comb begin
    win_word.addr       = req_addr[arb_winner*8 +: 8];
    win_word.float_mask = req_float[arb_winner*8 +: 8];
    win_word.data       = req_data[arb_winner*4 +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sync_q     <= 1'b0;
      hold       <= '0;
      hold_id    <= '0;
      last_grant <= GW'(N_REQ - 1);
      frame_cnt  <= '0;
      to_cnt     <= '0;
      ack        <= '0;
      abort      <= 1'b0;
      tx_active  <= 1'b0;
      grant_id   <= '0;
      enc_addr   <= '0;
      enc_float  <= '0;
      enc_data   <= '0;
    end else begin
      sync_q <= enc_sync;
      ack    <= '0;
      abort  <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (arb_valid) begin
            hold    <= win_word;
            hold_id <= arb_winner;
            state   <= ARM;
          end
        end

        ARM: begin
          if (rise) begin
            enc_addr  <= hold.addr;
            enc_float <= hold.float_mask;
            enc_data  <= hold.data;
            grant_id  <= hold_id;
            tx_active <= 1'b1;
            frame_cnt <= '0;
            to_cnt    <= '0;
            state     <= SEND;
          end else if (timeout_hit) begin
            abort  <= 1'b1;
            to_cnt <= '0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end

        SEND: begin
          if (rise) begin
            to_cnt <= '0;
            if (frame_cnt == LAST_FRAME) begin
              ack[grant_id] <= 1'b1;
              last_grant    <= grant_id;
              if (arb_valid) begin
                enc_addr  <= win_word.addr;
                enc_float <= win_word.float_mask;
                enc_data  <= win_word.data;
                grant_id  <= arb_winner;
                frame_cnt <= '0;
              end else begin
                tx_active <= 1'b0;
                state     <= IDLE;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end else if (timeout_hit) begin
            abort     <= 1'b1;
            tx_active <= 1'b0;
            to_cnt    <= '0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
